// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination-lock front end: lock FSM state
// encodings, the default dial size and the dial controller state enum.
package combo_lock_pkg;

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b011;
  localparam logic [2:0] S4 = 3'b100;

  localparam int DIAL_SIZE_DEF = 20;

  typedef enum logic [1:0] {
    CTRL_IDLE       = 2'd0,
    CTRL_PEND_REV   = 2'd1,
    CTRL_LOCKED_OUT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter for the lockout window; done is high during the
// cycle in which the running counter reads zero.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  localparam int TW = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [TW-1:0] count;
  logic          running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= TW'(LOCKOUT_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - TW'(1);
    end
  end

  assign done = running && (count == '0);

endmodule

// File: rtl/combo_lock_dial_controller.sv
// Dial front end for the lock FSM: turns detent pulses and the center button
// into Count and Right/Left/Center strobes, and enforces failed-attempt lockout.
module combo_lock_dial_controller
  import combo_lock_pkg::*;
#(
  parameter int DIAL_SIZE      = DIAL_SIZE_DEF,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int FW             = 2
) (
  input  logic          Clk,
  input  logic          South,
  input  logic          Step,
  input  logic          Dir,
  input  logic          CenterBtn,
  input  logic [2:0]    LockState,
  output logic [4:0]    Count,
  output logic          Right,
  output logic          Left,
  output logic          Center,
  output logic          Lockout,
  output logic [FW-1:0] Fails
);
  localparam logic [4:0]    LAST_POS  = 5'(DIAL_SIZE - 1);
  localparam logic [FW-1:0] FAILS_MAX = FW'(MAX_FAILS);

  ctrl_state_t state;
  logic        dir_valid, dir_last, pend_dir;
  logic        prev_btn, center_defer;
  logic        strobe_d1, strobe_d2;
  logic [2:0]  lock_prev;

  logic btn_rise, is_reversal, fail_event, success;
  logic lock_entry, lock_exit, lock_next, dir_strobe_due;
  logic timer_done;

  function automatic logic [4:0] step_pos(input logic [4:0] pos, input logic right);
    if (right) return (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
    return (pos == 5'd0) ? LAST_POS : pos - 5'd1;
  endfunction

  always_comb begin
    btn_rise       = CenterBtn & ~prev_btn;
    is_reversal    = ~dir_valid | (Dir != dir_last);
    // An attempt failed when the lock fell back to S0 right after we strobed it
    fail_event     = ((lock_prev == S1) || (lock_prev == S2) || (lock_prev == S3))
                     && (LockState == S0) && strobe_d2;
    success        = (LockState == S4);
    lock_entry     = (Fails == FAILS_MAX) && (state != CTRL_LOCKED_OUT);
    lock_exit      = (state == CTRL_LOCKED_OUT) && timer_done;
    lock_next      = lock_entry | (Lockout & ~lock_exit);
    dir_strobe_due = (state == CTRL_IDLE) && Step && is_reversal && !lock_entry;
  end

  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk   (Clk),
    .rst_n (South),
    .load  (lock_entry),
    .done  (timer_done)
  );

  always_ff @(posedge Clk or negedge South) begin
    if (!South) begin
      state        <= CTRL_IDLE;
      Count        <= 5'd0;
      Right        <= 1'b0;
      Left         <= 1'b0;
      Center       <= 1'b0;
      Lockout      <= 1'b0;
      Fails        <= '0;
      dir_valid    <= 1'b0;
      dir_last     <= 1'b0;
      pend_dir     <= 1'b0;
      prev_btn     <= 1'b0;
      center_defer <= 1'b0;
      strobe_d1    <= 1'b0;
      strobe_d2    <= 1'b0;
      lock_prev    <= S0;
    end else begin
      Right     <= 1'b0;
      Left      <= 1'b0;
      Center    <= 1'b0;
      prev_btn  <= CenterBtn;
      lock_prev <= LockState;
      strobe_d1 <= Right | Left | Center;
      strobe_d2 <= strobe_d1;
      Lockout   <= lock_next;

      if (lock_exit || success)                  Fails <= '0;
      else if (fail_event && Fails != FAILS_MAX) Fails <= Fails + FW'(1);

      // Center yields one cycle to a direction strobe due at the same time
      if (lock_next) begin
        center_defer <= 1'b0;
      end else if (center_defer) begin
        Center       <= 1'b1;
        center_defer <= 1'b0;
      end else if (btn_rise) begin
        if (dir_strobe_due) center_defer <= 1'b1;
        else                Center       <= 1'b1;
      end

      case (state)
        CTRL_IDLE: begin
          if (Step) begin
            if (lock_entry || !is_reversal) begin
              Count <= step_pos(Count, Dir);
            end else begin
              Right    <= Dir;
              Left     <= ~Dir;
              pend_dir <= Dir;
              state    <= CTRL_PEND_REV;
            end
          end
        end
        CTRL_PEND_REV: begin
          Count     <= step_pos(Count, pend_dir);
          dir_last  <= pend_dir;
          dir_valid <= 1'b1;
          state     <= CTRL_IDLE;
        end
        CTRL_LOCKED_OUT: begin
          if (Step)      Count <= step_pos(Count, Dir);
          if (lock_exit) state <= CTRL_IDLE;
        end
        default: state <= CTRL_IDLE;
      endcase

      if (lock_entry) begin
        state     <= CTRL_LOCKED_OUT;
        dir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_combo_lock_dial_controller.sv
// Bench for combo_lock_dial_controller: directed scenarios plus random traffic,
// every cycle compared against a cycle-stamped reference model.
module tb_combo_lock_dial_controller;

  localparam int DIAL = 20;
  localparam int MAXF = 3;
  localparam int LCYC = 16;
  localparam int FW   = 2;
  localparam int W    = 5 + 4 + FW;

  logic          Clk, South, Step, Dir, CenterBtn;
  logic [2:0]    LockState;
  logic [4:0]    Count;
  logic          Right, Left, Center, Lockout;
  logic [FW-1:0] Fails;

  combo_lock_dial_controller #(
    .DIAL_SIZE(DIAL), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LCYC), .FW(FW)
  ) dut (
    .Clk(Clk), .South(South), .Step(Step), .Dir(Dir), .CenterBtn(CenterBtn),
    .LockState(LockState), .Count(Count), .Right(Right), .Left(Left),
    .Center(Center), .Lockout(Lockout), .Fails(Fails)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // reference model: cycle index, dial position, strobe schedule, lockout window
  int n, m_count, m_fails, lock_start, lock_end, last_dir, pend_dir, last_step, prev_ls;
  bit m_right, m_left, m_center, pend, defer, prev_btn;
  bit strobe_hist[int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  function automatic int move(input int c, input bit right);
    return right ? (c + 1) % DIAL : (c + DIAL - 1) % DIAL;
  endfunction

  function automatic bit locked(input int c);
    return (c >= lock_start) && (c < lock_end);
  endfunction

  function automatic logic [W-1:0] exp_vec();
    return {5'(m_count), m_right, m_left, m_center, locked(n), FW'(m_fails)};
  endfunction

  function automatic bit rev_dir();
    return (last_dir < 0) ? 1'b1 : (last_dir == 0);
  endfunction

  task automatic model_reset();
    n = 0; m_count = 0; m_fails = 0;
    lock_start = -1; lock_end = -1;
    last_dir = -1; pend_dir = 0; last_step = -10; prev_ls = 0;
    m_right = 0; m_left = 0; m_center = 0; pend = 0; defer = 0; prev_btn = 0;
    strobe_hist.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit step, input bit dir, input bit btn, input logic [2:0] ls);
    bit lock_now, lock_nx, fail, dir_due, nr, nl, nc;
    int nf;
    lock_now = locked(n);
    strobe_hist[n] = m_right | m_left | m_center;
    fail = (prev_ls >= 1) && (prev_ls <= 3) && (ls == 3'd0) && (n >= 2)
           && strobe_hist.exists(n - 2) && strobe_hist[n - 2];
    nf = m_fails;
    if (lock_now && (n + 1 == lock_end)) nf = 0;
    else if (ls == 3'd4)                 nf = 0;
    else if (fail && m_fails < MAXF)     nf = m_fails + 1;
    if (!lock_now && m_fails == MAXF) begin
      lock_start = n + 1;
      lock_end   = n + 1 + LCYC;
    end
    lock_nx = locked(n + 1);
    nr = 0; nl = 0; nc = 0; dir_due = 0;
    if (pend) begin
      m_count  = move(m_count, pend_dir[0]);
      last_dir = pend_dir;
      pend     = 0;
    end else if (step) begin
      if (lock_now || lock_nx) m_count = move(m_count, dir);
      else if (last_dir < 0 || int'(dir) != last_dir) begin
        dir_due = 1; nr = dir; nl = !dir; pend = 1; pend_dir = int'(dir);
      end else m_count = move(m_count, dir);
    end
    if (lock_nx) last_dir = -1;
    if (lock_nx) defer = 0;
    else if (defer) begin nc = 1; defer = 0; end
    else if (btn && !prev_btn) begin
      if (dir_due) defer = 1;
      else         nc = 1;
    end
    prev_btn = btn; prev_ls = int'(ls);
    m_fails = nf; m_right = nr; m_left = nl; m_center = nc;
    n++;
    exp_q.push_back(exp_vec());
  endtask

  task automatic check_outputs(input logic [W-1:0] e);
    check_val("count",   Count,   e[W-1:W-5]);
    check_val("right",   Right,   e[W-6]);
    check_val("left",    Left,    e[W-7]);
    check_val("center",  Center,  e[W-8]);
    check_val("lockout", Lockout, e[FW]);
    check_val("fails",   Fails,   e[FW-1:0]);
  endtask

  // driver: one cycle of inputs, then compare the following cycle's outputs
  task automatic tick(input bit step, input bit dir, input bit btn, input logic [2:0] ls);
    bit s;
    s = step;
    if (s && (n - last_step < 2)) s = 0;
    if (s) last_step = n;
    Step = s; Dir = dir; CenterBtn = btn; LockState = ls;
    model_step(s, dir, btn, ls);
    @(posedge Clk);
    @(negedge Clk);
    if (exp_q.size() == 0) check_val("queue_empty", 1, 0);
    else check_outputs(exp_q.pop_front());
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(0, 0, 0, combo_lock_pkg::S0);
  endtask

  task automatic fail_round();
    tick(1, rev_dir(), 0, combo_lock_pkg::S0);
    tick(0, 0, 0, combo_lock_pkg::S0);
    tick(0, 0, 0, combo_lock_pkg::S1);
    tick(0, 0, 0, combo_lock_pkg::S0);
    tick(0, 0, 0, combo_lock_pkg::S0);
  endtask

  initial begin
    bit btn_lvl;
    logic [2:0] ls;
    South = 1'b0; Step = 0; Dir = 0; CenterBtn = 0; LockState = 3'd0;
    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_outputs(exp_vec());
    South = 1'b1;

    // first step is a reversal, then dial wrap in both directions
    tick(1, 1, 0, combo_lock_pkg::S0);
    idle(2);
    for (int i = 0; i < 25 && m_count != 19; i++) begin
      tick(1, 1, 0, combo_lock_pkg::S0);
      tick(0, 0, 0, combo_lock_pkg::S0);
    end
    tick(1, 1, 0, combo_lock_pkg::S0);
    idle(1);
    for (int i = 0; i < 24; i++) begin
      tick(1, 0, 0, combo_lock_pkg::S0);
      tick(0, 0, 0, combo_lock_pkg::S0);
    end

    // right to 13, reverse left, then a center press
    for (int i = 0; i < 25 && m_count != 13; i++) begin
      tick(1, 1, 0, combo_lock_pkg::S0);
      tick(0, 0, 0, combo_lock_pkg::S0);
    end
    tick(1, 0, 0, combo_lock_pkg::S0);
    idle(2);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, combo_lock_pkg::S0);
    idle(2);

    // three failures -> lockout window -> recovery
    for (int i = 0; i < 3; i++) fail_round();
    for (int i = 0; i < LCYC + 4; i++) tick((i % 3) == 0, i[0], i[1], combo_lock_pkg::S0);
    idle(2);

    // two failures then success clears the count
    fail_round();
    fail_round();
    tick(0, 0, 0, combo_lock_pkg::S4);
    idle(4);

    // center edge together with a reversal step
    tick(1, rev_dir(), 1, combo_lock_pkg::S0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, combo_lock_pkg::S0);
    idle(2);

    // random traffic
    btn_lvl = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_lvl = !btn_lvl;
      case ($urandom_range(0, 9))
        6: ls = 3'd1;
        7: ls = 3'd2;
        8: ls = 3'd3;
        9: ls = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'd0;
        default: ls = 3'd0;
      endcase
      tick($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), btn_lvl, ls);
    end
    idle(LCYC + 4);

    // asynchronous reset while a reversal step is pending
    tick(1, rev_dir(), 0, combo_lock_pkg::S0);
    #1;
    South = 1'b0; Step = 0; Dir = 0; CenterBtn = 0; LockState = 3'd0;
    #1;
    model_reset();
    check_outputs(exp_vec());
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    South = 1'b1;
    check_outputs(exp_vec());
    tick(1, 1, 0, combo_lock_pkg::S0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
